forward_hazard_unit: RTL and testbench

- Control-side counterpart of the execute stage: generates the operand-select codes the execute stage consumes (mux1/mux2/mux3).
- Tracks destination registers of in-flight instructions (EX, MEM, WB shadow pipeline) and detects load-use hazards.
- Issues a one-cycle stall with bubble insertion on a load-use hazard.
- Sits between decode and execute in the RV32IM_Zbb pipeline.

---
 rtl/forward_hazard_unit.sv | 209 ++++++++++++++++++++
 tb/tb_forward_hazard_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/forward_hazard_unit.sv
// forward_hazard_unit
//   Control-side partner of the execute stage. It keeps a shadow copy of the
//   EX/MEM/WB destination info and from that produces the registered
//   operand-select codes for EX (mux1/mux2/mux3). It also detects load-use
//   hazards and answers them with a one-cycle stall plus an EX bubble.
//
//   Optional feature macro: HAZARD_PERF_CNT_EN
//     When it is defined, the module has load-use stall and forwarded-operand
//     counters. When it is undefined, stall_cnt_o and fwd_cnt_o are tied to 0
//     and no counter flops are built.
//
//   Ports
//     clk, rst_n            clock (rising edge), async active-low reset
//     id_*_i                decode-stage instruction fields
//     flush_i               redirect: kill the decode instruction (bubble)
//     hold_i                freeze everything (memory busy)
//     mux1_o / mux2_o       operand select: 00 rs, 01 mem_wb, 10 ex_mem, 11 zero
//     mux3_o                1 = immediate drives operand 2
//     stall_o               combinational: hold PC and IF/ID this cycle
//     ex_valid_o            instruction in EX is valid (0 = bubble)
//     stall_cnt_o/fwd_cnt_o performance counters (optional)
module forward_hazard_unit #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_uses_rs1_i,
  input  logic              id_uses_rs2_i,
  input  logic              id_use_imm_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_reg_write_i,
  input  logic              id_mem_read_i,
  input  logic              flush_i,
  input  logic              hold_i,
  output logic [1:0]        mux1_o,
  output logic [1:0]        mux2_o,
  output logic              mux3_o,
  output logic              stall_o,
  output logic              ex_valid_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  fwd_cnt_o
);

  localparam logic [1:0] SEL_RS   = 2'b00;
  localparam logic [1:0] SEL_MEM  = 2'b01;
  localparam logic [1:0] SEL_EX   = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  // What the hazard logic needs to know about an in-flight instruction.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } shadow_t;

  state_e     state_q, state_d;
  shadow_t    ex_q, ex_d;
  shadow_t    mem_q, mem_d;
  shadow_t    wb_q, wb_d;
  logic [1:0] mux1_q, mux1_d;
  logic [1:0] mux2_q, mux2_d;
  logic       mux3_q, mux3_d;
  logic       ex_valid_q, ex_valid_d;

  logic       rs1_hit_load_c;
  logic       rs2_hit_load_c;
  logic       load_use_c;
  logic       stall_c;
  logic       enter_c;

  // Select code for one source operand; the first matching rule wins.
  function automatic logic [1:0] sel_code(
    input logic              uses,
    input logic [REG_AW-1:0] rs,
    input shadow_t           ex_s,
    input shadow_t           mem_s
  );
    logic [1:0] code;
    code = SEL_RS;
    if (!uses) begin
      code = SEL_RS;
    end else if (rs == '0) begin
      code = SEL_ZERO;
    end else if (ex_s.valid && ex_s.reg_write && (ex_s.rd == rs)) begin
      code = SEL_EX;
    end else if (mem_s.valid && mem_s.reg_write && (mem_s.rd == rs)) begin
      code = SEL_MEM;
    end
    return code;
  endfunction

  // Load-use detection against the instruction that is currently in EX.
  always_comb begin
    rs1_hit_load_c = id_uses_rs1_i && (id_rs1_i == ex_q.rd);
    rs2_hit_load_c = id_uses_rs2_i && (id_rs2_i == ex_q.rd);
    load_use_c     = id_valid_i && ex_q.valid && ex_q.mem_read &&
                     (ex_q.rd != '0) && (rs1_hit_load_c || rs2_hit_load_c);
    // STALL state blocks a second stall; flush cancels the stall outright.
    stall_c        = (state_q == ST_RUN) && load_use_c && !flush_i;
    enter_c        = id_valid_i && !flush_i && !stall_c;
  end

  assign stall_o = stall_c;

  // Next-state: shift the shadow pipe and compute EX-entry selects.
  always_comb begin
    state_d    = state_q;
    ex_d       = ex_q;
    mem_d      = mem_q;
    wb_d       = wb_q;
    mux1_d     = mux1_q;
    mux2_d     = mux2_q;
    mux3_d     = mux3_q;
    ex_valid_d = ex_valid_q;

    if (!hold_i) begin
      wb_d       = mem_q;
      mem_d      = ex_q;
      ex_d       = '0;
      mux1_d     = SEL_RS;
      mux2_d     = SEL_RS;
      mux3_d     = id_use_imm_i;
      ex_valid_d = 1'b0;
      state_d    = stall_c ? ST_STALL : ST_RUN;

      if (enter_c) begin
        ex_d.valid     = 1'b1;
        ex_d.rd        = id_rd_i;
        ex_d.reg_write = id_reg_write_i;
        ex_d.mem_read  = id_mem_read_i;
        ex_valid_d     = 1'b1;
        mux1_d         = sel_code(id_uses_rs1_i, id_rs1_i, ex_q, mem_q);
        mux2_d         = sel_code(id_uses_rs2_i, id_rs2_i, ex_q, mem_q);
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      ex_q       <= '0;
      mem_q      <= '0;
      wb_q       <= '0;
      mux1_q     <= SEL_RS;
      mux2_q     <= SEL_RS;
      mux3_q     <= 1'b0;
      ex_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ex_q       <= ex_d;
      mem_q      <= mem_d;
      wb_q       <= wb_d;
      mux1_q     <= mux1_d;
      mux2_q     <= mux2_d;
      mux3_q     <= mux3_d;
      ex_valid_q <= ex_valid_d;
    end
  end

  assign mux1_o     = mux1_q;
  assign mux2_o     = mux2_q;
  assign mux3_o     = mux3_q;
  assign ex_valid_o = ex_valid_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;
  logic [1:0]       fwd_inc_c;

  // Codes 01 and 10 are the forwarded ones; bubbles always carry 00.
  always_comb begin
    fwd_inc_c   = 2'(mux1_d[0] ^ mux1_d[1]) + 2'(mux2_d[0] ^ mux2_d[1]);
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (!hold_i) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(stall_c);
      fwd_cnt_d   = fwd_cnt_q + CNT_W'(fwd_inc_c);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign fwd_cnt_o   = fwd_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign fwd_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Bench for forward_hazard_unit: directed vector table, reset-in-stall
// sequence, then randomized traffic checked against a queue-based model.
module tb_forward_hazard_unit;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 32;

  logic              clk;
  logic              rst_n;
  logic              id_valid_i;
  logic [REG_AW-1:0] id_rs1_i, id_rs2_i, id_rd_i;
  logic              id_uses_rs1_i, id_uses_rs2_i, id_use_imm_i;
  logic              id_reg_write_i, id_mem_read_i;
  logic              flush_i, hold_i;
  logic [1:0]        mux1_o, mux2_o;
  logic              mux3_o, stall_o, ex_valid_o;
  logic [CNT_W-1:0]  stall_cnt_o, fwd_cnt_o;

  forward_hazard_unit #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_uses_rs1_i(id_uses_rs1_i), .id_uses_rs2_i(id_uses_rs2_i),
    .id_use_imm_i(id_use_imm_i), .id_rd_i(id_rd_i),
    .id_reg_write_i(id_reg_write_i), .id_mem_read_i(id_mem_read_i),
    .flush_i(flush_i), .hold_i(hold_i),
    .mux1_o(mux1_o), .mux2_o(mux2_o), .mux3_o(mux3_o), .stall_o(stall_o),
    .ex_valid_o(ex_valid_o), .stall_cnt_o(stall_cnt_o), .fwd_cnt_o(fwd_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       v;
    logic [4:0] rs1; logic u1;
    logic [4:0] rs2; logic u2;
    logic       imm;
    logic [4:0] rd;  logic rw; logic ld;
    logic       fl;  logic hd;
    logic       es;
    logic [1:0] m1;  logic [1:0] m2; logic m3; logic exv;
  } vec_t;

  function automatic vec_t mk(
    input logic v, input int rs1, input logic u1, input int rs2, input logic u2,
    input logic imm, input int rd, input logic rw, input logic ld,
    input logic fl, input logic hd,
    input logic es, input logic [1:0] m1, input logic [1:0] m2, input logic m3, input logic exv);
    vec_t r;
    r.v = v; r.rs1 = 5'(rs1); r.u1 = u1; r.rs2 = 5'(rs2); r.u2 = u2; r.imm = imm;
    r.rd = 5'(rd); r.rw = rw; r.ld = ld; r.fl = fl; r.hd = hd;
    r.es = es; r.m1 = m1; r.m2 = m2; r.m3 = m3; r.exv = exv;
    return r;
  endfunction

  task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic imm,
                       input logic [4:0] rd, input logic rw, input logic ld,
                       input logic fl, input logic hd);
    id_valid_i = v; id_rs1_i = rs1; id_uses_rs1_i = u1; id_rs2_i = rs2;
    id_uses_rs2_i = u2; id_use_imm_i = imm; id_rd_i = rd;
    id_reg_write_i = rw; id_mem_read_i = ld; flush_i = fl; hold_i = hd;
  endtask

  // ---------------- reference model ----------------
  // pipe[0] = instruction in EX, pipe[1] = MEM, pipe[2] = WB.
  typedef struct { bit v; int rd; bit rw; bit ld; } slot_t;
  slot_t      pipe[3];
  bit         m_prev_stalled;
  logic [1:0] e_m1, e_m2;
  logic       e_m3, e_exv, e_stall;
  logic [CNT_W-1:0] e_scnt, e_fcnt;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0};
    m_prev_stalled = 0;
    e_m1 = 0; e_m2 = 0; e_m3 = 0; e_exv = 0; e_stall = 0;
    e_scnt = 0; e_fcnt = 0;
  endtask

  function automatic logic [1:0] m_code(input bit uses, input int rs);
    if (!uses) return 2'd0;
    if (rs == 0) return 2'd3;
    if (pipe[0].v && pipe[0].rw && pipe[0].rd == rs) return 2'd2;
    if (pipe[1].v && pipe[1].rw && pipe[1].rd == rs) return 2'd1;
    return 2'd0;
  endfunction

  // Computes the pre-edge stall and, unless held, the post-edge outputs.
  task automatic model_step(input bit v, input int rs1, input bit u1, input int rs2,
                            input bit u2, input bit imm, input int rd, input bit rw,
                            input bit ld, input bit fl, input bit hd);
    bit    hz, enter;
    slot_t ns;
    int    nfwd;
    hz = !m_prev_stalled && v && !fl && pipe[0].v && pipe[0].ld && pipe[0].rd != 0 &&
         ((u1 && rs1 == pipe[0].rd) || (u2 && rs2 == pipe[0].rd));
    e_stall = hz;
    if (hd) return;
    enter = v && !fl && !hz;
    ns = '{0, 0, 0, 0};
    e_m1 = 0; e_m2 = 0;
    if (enter) begin
      e_m1 = m_code(u1, rs1);
      e_m2 = m_code(u2, rs2);
      ns = '{1, rd, rw, ld};
    end
    e_m3 = imm;
    e_exv = enter;
    nfwd = ((e_m1 == 1 || e_m1 == 2) ? 1 : 0) + ((e_m2 == 1 || e_m2 == 2) ? 1 : 0);
    e_fcnt = e_fcnt + CNT_W'(nfwd);
    e_scnt = e_scnt + CNT_W'(hz);
    pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = ns;
    m_prev_stalled = hz;
  endtask

  task automatic check_counters(input string tag, input logic [CNT_W-1:0] s, input logic [CNT_W-1:0] f);
`ifdef HAZARD_PERF_CNT_EN
    chk({tag, "_stall_cnt"}, 64'(stall_cnt_o), 64'(s));
    chk({tag, "_fwd_cnt"}, 64'(fwd_cnt_o), 64'(f));
`else
    chk({tag, "_stall_cnt_tied"}, 64'(stall_cnt_o), 64'(0) + 64'(s & 0));
    chk({tag, "_fwd_cnt_tied"}, 64'(fwd_cnt_o), 64'(0) + 64'(f & 0));
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t vecs[$];

  initial begin
    // Directed table: each entry = decode inputs for one cycle and the
    // expected stall (before the edge) and EX-entry outputs (after it).
    //            v rs1 u1 rs2 u2 imm rd rw ld fl hd | es m1 m2 m3 exv
    vecs.push_back(mk(1, 1,1, 2,1, 0, 5,1,0, 0,0, 0,2'b00,2'b00,0,1)); // add x5,x1,x2
    vecs.push_back(mk(1, 5,1, 1,1, 0, 6,1,0, 0,0, 0,2'b10,2'b00,0,1)); // sub x6,x5,x1
    vecs.push_back(mk(0, 0,0, 0,0, 0, 0,0,0, 0,0, 0,2'b00,2'b00,0,0)); // no instr
    vecs.push_back(mk(1, 1,1, 2,1, 0, 5,1,0, 0,0, 0,2'b00,2'b00,0,1)); // add x5,x1,x2
    vecs.push_back(mk(0, 0,0, 0,0, 0, 0,0,0, 0,0, 0,2'b00,2'b00,0,0)); // nop gap
    vecs.push_back(mk(1, 1,1, 5,1, 0, 7,1,0, 0,0, 0,2'b00,2'b01,0,1)); // and x7,x1,x5
    vecs.push_back(mk(1, 1,1, 0,0, 1, 8,1,1, 0,0, 0,2'b00,2'b00,1,1)); // lw x8
    vecs.push_back(mk(1, 8,1, 8,1, 0, 9,1,0, 0,0, 1,2'b00,2'b00,0,0)); // add x9,x8,x8 stall
    vecs.push_back(mk(1, 8,1, 8,1, 0, 9,1,0, 0,0, 0,2'b01,2'b01,0,1)); // re-issue
    vecs.push_back(mk(1, 1,1, 2,1, 0, 0,1,0, 0,0, 0,2'b00,2'b00,0,1)); // add x0,x1,x2
    vecs.push_back(mk(1, 0,1, 0,1, 0, 3,1,0, 0,0, 0,2'b11,2'b11,0,1)); // add x3,x0,x0
    vecs.push_back(mk(1, 1,1, 0,0, 1, 8,1,1, 0,0, 0,2'b00,2'b00,1,1)); // lw x8
    vecs.push_back(mk(1, 8,1, 1,1, 0, 9,1,0, 1,0, 0,2'b00,2'b00,0,0)); // flush on hazard
    vecs.push_back(mk(1, 8,1, 1,1, 0, 9,1,0, 0,0, 0,2'b01,2'b00,0,1)); // load now in MEM
    vecs.push_back(mk(1, 2,1, 0,0, 1,10,1,1, 0,0, 0,2'b00,2'b00,1,1)); // lw x10
    vecs.push_back(mk(1,10,1, 3,1, 0,11,1,0, 0,1, 1,2'b00,2'b00,1,1)); // held x3
    vecs.push_back(mk(1,10,1, 3,1, 0,11,1,0, 0,1, 1,2'b00,2'b00,1,1));
    vecs.push_back(mk(1,10,1, 3,1, 0,11,1,0, 0,1, 1,2'b00,2'b00,1,1));
    vecs.push_back(mk(1,10,1, 3,1, 0,11,1,0, 0,0, 1,2'b00,2'b00,0,0)); // released: stall
    vecs.push_back(mk(1,10,1, 3,1, 0,11,1,0, 0,0, 0,2'b01,2'b00,0,1)); // resumes

    do_reset();
    #1;
    chk("rst_mux1", 64'(mux1_o), 64'(0));
    chk("rst_mux2", 64'(mux2_o), 64'(0));
    chk("rst_mux3", 64'(mux3_o), 64'(0));
    chk("rst_stall", 64'(stall_o), 64'(0));
    chk("rst_exv", 64'(ex_valid_o), 64'(0));
    check_counters("rst", 0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].rs1, vecs[i].u1, vecs[i].rs2, vecs[i].u2, vecs[i].imm,
            vecs[i].rd, vecs[i].rw, vecs[i].ld, vecs[i].fl, vecs[i].hd);
      #1;
      chk($sformatf("vec%0d_stall", i), 64'(stall_o), 64'(vecs[i].es));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_mux1", i), 64'(mux1_o), 64'(vecs[i].m1));
      chk($sformatf("vec%0d_mux2", i), 64'(mux2_o), 64'(vecs[i].m2));
      chk($sformatf("vec%0d_mux3", i), 64'(mux3_o), 64'(vecs[i].m3));
      chk($sformatf("vec%0d_exv", i), 64'(ex_valid_o), 64'(vecs[i].exv));
    end
    // Stalls at the two released hazards; forwards 1+1+2+1+1.
    check_counters("table", 2, 6);

    // Reset asserted while a stall is being requested.
    do_reset();
    @(negedge clk);
    drive(1, 1, 1, 0, 0, 1, 8, 1, 1, 0, 0);           // lw x8
    @(negedge clk);
    drive(1, 8, 1, 8, 1, 0, 9, 1, 0, 0, 0);           // add x9,x8,x8
    #1;
    chk("pre_rst_stall", 64'(stall_o), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("async_rst_stall", 64'(stall_o), 64'(0));
    chk("async_rst_exv", 64'(ex_valid_o), 64'(0));
    chk("async_rst_mux3", 64'(mux3_o), 64'(0));
    chk("async_rst_mux", 64'({mux1_o, mux2_o}), 64'(0));
    check_counters("async_rst", 0, 0);

    // Randomized traffic against the model.
    do_reset();
    model_reset();
    for (int n = 0; n < 600; n++) begin
      bit v, u1, u2, imm, rw, ld, fl, hd;
      int rs1, rs2, rd;
      v   = ($urandom_range(0, 7) != 0);
      rs1 = $urandom_range(0, 3);
      rs2 = $urandom_range(0, 3);
      rd  = $urandom_range(0, 3);
      u1  = ($urandom_range(0, 5) != 0);
      u2  = ($urandom_range(0, 2) != 0);
      imm = $urandom_range(0, 1);
      ld  = ($urandom_range(0, 2) == 0);
      rw  = ld || ($urandom_range(0, 4) != 0);
      fl  = ($urandom_range(0, 9) == 0);
      hd  = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      drive(v, 5'(rs1), u1, 5'(rs2), u2, imm, 5'(rd), rw, ld, fl, hd);
      model_step(v, rs1, u1, rs2, u2, imm, rd, rw, ld, fl, hd);
      #1;
      chk("rnd_stall", 64'(stall_o), 64'(e_stall));
      @(posedge clk);
      #1;
      chk("rnd_mux1", 64'(mux1_o), 64'(e_m1));
      chk("rnd_mux2", 64'(mux2_o), 64'(e_m2));
      chk("rnd_mux3", 64'(mux3_o), 64'(e_m3));
      chk("rnd_exv", 64'(ex_valid_o), 64'(e_exv));
      check_counters("rnd", e_scnt, e_fcnt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
